commit_trace_sched: RTL and testbench

Commit-trace scheduler between the dual-retire commit stage and the single-port `Debug` sink. Accepts up to two retired instructions per cycle in program order and buffers them in a small FIFO. Presents exactly one commit per cycle on the `debug_*` port. Enforces halt ordering: the halting instruction is the last commit ever reported.

---
 rtl/trace_pkg.sv | 16 +
 rtl/trace_fifo.sv | 44 ++++
 rtl/commit_trace_sched.sv | 115 +++++++++++
 tb/tb_commit_trace_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types for the commit-trace scheduler
package trace_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            regWen;
        logic [4:0]      regWaddr;
        logic [XLEN-1:0] regWdata;
        logic            halt;
    } commit_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} sched_state_e;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - 2-write/1-read FIFO of commit entries
module trace_fifo
    import trace_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push0,
    input  commit_t       push0_data,
    input  logic          push1,
    input  commit_t       push1_data,
    input  logic          pop,
    output commit_t       head,
    output logic [CW-1:0] count
);

    commit_t       mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    assign head = mem[rptr];

    // push1 is only ever raised together with push0, so it lands in the slot after push0
    always_ff @(posedge clock) begin
        if (push0) mem[wptr] <= push0_data;
        if (push1) mem[wptr + AW'(1)] <= push1_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(push0) + AW'(push1);
            if (pop) rptr <= rptr + AW'(1);
            count <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

endmodule

// File: rtl/commit_trace_sched.sv
// rtl/commit_trace_sched.sv - dual-retire to single-port debug commit scheduler
module commit_trace_sched
    import trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            c0_valid,
    input  logic            c0_halt,
    input  logic            c0_regWen,
    input  logic [XLEN-1:0] c0_pc,
    input  logic [4:0]      c0_regWaddr,
    input  logic [XLEN-1:0] c0_regWdata,
    input  logic            c1_valid,
    input  logic            c1_halt,
    input  logic            c1_regWen,
    input  logic [XLEN-1:0] c1_pc,
    input  logic [4:0]      c1_regWaddr,
    input  logic [XLEN-1:0] c1_regWdata,
    output logic            in_ready,
    output logic            debug_valid,
    output logic            debug_halt,
    output logic            debug_regWen,
    output logic [XLEN-1:0] debug_pc,
    output logic [XLEN-1:0] debug_regWdata,
    output logic [4:0]      debug_regWaddr,
    output logic            sched_halted
);

    localparam int CW = $clog2(DEPTH) + 1;

    sched_state_e  state, state_next;
    commit_t       lane0, lane1, head, push0_data, out_entry;
    logic [CW-1:0] count;
    logic          tx0, tx1, push0, push1, pop, load;

    assign lane0 = {c0_pc, c0_regWen, c0_regWaddr, c0_regWdata, c0_halt};
    assign lane1 = {c1_pc, c1_regWen, c1_regWaddr, c1_regWdata, c1_halt};

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push0      (push0),
        .push0_data (push0_data),
        .push1      (push1),
        .push1_data (lane1),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        push0      = 1'b0;
        push1      = 1'b0;
        push0_data = lane1;
        load       = 1'b0;
        out_entry  = lane0;
        in_ready   = (state == RUN) && ((CW'(DEPTH) - count) >= CW'(2));
        tx0        = in_ready && c0_valid;
        // a halting lane 0 swallows the younger lane 1
        tx1        = in_ready && c1_valid && !(tx0 && c0_halt);

        if (count != '0) begin
            pop        = 1'b1;
            load       = 1'b1;
            out_entry  = head;
            push0      = tx0 || tx1;
            push0_data = tx0 ? lane0 : lane1;
            push1      = tx0 && tx1;
        end else if (tx0 || tx1) begin
            load      = 1'b1;
            out_entry = tx0 ? lane0 : lane1;
            push0     = tx0 && tx1;
        end

        case (state)
            RUN:     if ((tx0 && c0_halt) || (tx1 && c1_halt)) state_next = DRAIN;
            // a bypassed halt is already on the port when DRAIN is entered
            DRAIN:   if ((load && out_entry.halt) || (debug_valid && debug_halt)) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            debug_valid    <= 1'b0;
            debug_halt     <= 1'b0;
            debug_regWen   <= 1'b0;
            debug_pc       <= '0;
            debug_regWaddr <= '0;
            debug_regWdata <= '0;
            sched_halted   <= 1'b0;
        end else begin
            debug_valid <= load;
            if (load) begin
                debug_halt     <= out_entry.halt;
                debug_regWen   <= out_entry.regWen && (out_entry.regWaddr != 5'd0);
                debug_pc       <= out_entry.pc;
                debug_regWaddr <= out_entry.regWaddr;
                debug_regWdata <= out_entry.regWdata;
            end
            if (load && out_entry.halt) sched_halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_commit_trace_sched.sv
// tb/tb_commit_trace_sched.sv - directed and random checks against a queue model
`timescale 1ns/1ps
module tb_commit_trace_sched;
    import trace_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        c0_valid = 1'b0, c0_halt = 1'b0, c0_regWen = 1'b0;
    logic [31:0] c0_pc = '0, c0_regWdata = '0;
    logic [4:0]  c0_regWaddr = '0;
    logic        c1_valid = 1'b0, c1_halt = 1'b0, c1_regWen = 1'b0;
    logic [31:0] c1_pc = '0, c1_regWdata = '0;
    logic [4:0]  c1_regWaddr = '0;
    logic        in_ready, debug_valid, debug_halt, debug_regWen, sched_halted;
    logic [31:0] debug_pc, debug_regWdata;
    logic [4:0]  debug_regWaddr;

    commit_trace_sched #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .c0_valid(c0_valid), .c0_halt(c0_halt), .c0_regWen(c0_regWen), .c0_pc(c0_pc),
        .c0_regWaddr(c0_regWaddr), .c0_regWdata(c0_regWdata),
        .c1_valid(c1_valid), .c1_halt(c1_halt), .c1_regWen(c1_regWen), .c1_pc(c1_pc),
        .c1_regWaddr(c1_regWaddr), .c1_regWdata(c1_regWdata),
        .in_ready(in_ready), .debug_valid(debug_valid), .debug_halt(debug_halt),
        .debug_regWen(debug_regWen), .debug_pc(debug_pc), .debug_regWdata(debug_regWdata),
        .debug_regWaddr(debug_regWaddr), .sched_halted(sched_halted)
    );

    always #5 clock = ~clock;

    commit_t     mq[$];
    bit          m_halt_taken, m_halted;
    int          tests, failed;
    bit          trk, saw_stall;
    logic [31:0] trk_pc;
    int          trk_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic commit_t mk(logic [31:0] pc, logic wen, logic [4:0] wa, logic [31:0] wd, logic h);
        commit_t e;
        e.pc = pc; e.regWen = wen; e.regWaddr = wa; e.regWdata = wd; e.halt = h;
        return e;
    endfunction

    task automatic set_l0(input logic v, input commit_t e);
        c0_valid = v; c0_pc = e.pc; c0_regWen = e.regWen;
        c0_regWaddr = e.regWaddr; c0_regWdata = e.regWdata; c0_halt = e.halt;
    endtask

    task automatic set_l1(input logic v, input commit_t e);
        c1_valid = v; c1_pc = e.pc; c1_regWen = e.regWen;
        c1_regWaddr = e.regWaddr; c1_regWdata = e.regWdata; c1_halt = e.halt;
    endtask

    // One clock: the model holds every accepted-but-unemitted entry except the one on the port.
    task automatic cycle(output bit acc);
        commit_t e;
        bit      rdy, exp_v;
        rdy = !m_halt_taken && ((DEPTH - mq.size()) >= 2);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        acc = rdy;
        if (rdy) begin
            if (c0_valid) begin
                mq.push_back(mk(c0_pc, c0_regWen, c0_regWaddr, c0_regWdata, c0_halt));
                if (c0_halt) m_halt_taken = 1'b1;
            end
            if (c1_valid && !(c0_valid && c0_halt)) begin
                mq.push_back(mk(c1_pc, c1_regWen, c1_regWaddr, c1_regWdata, c1_halt));
                if (c1_halt) m_halt_taken = 1'b1;
            end
        end
        @(posedge clock); #1;
        exp_v = 1'b0;
        if (mq.size() > 0) begin
            e = mq.pop_front();
            exp_v = 1'b1;
            if (e.halt) m_halted = 1'b1;
        end
        chk("debug_valid", 32'(debug_valid), 32'(exp_v));
        if (exp_v) begin
            chk("debug_pc", debug_pc, e.pc);
            chk("debug_regWaddr", 32'(debug_regWaddr), 32'(e.regWaddr));
            chk("debug_regWdata", debug_regWdata, e.regWdata);
            chk("debug_regWen", 32'(debug_regWen), 32'(e.regWen && (e.regWaddr != 5'd0)));
            chk("debug_halt", 32'(debug_halt), 32'(e.halt));
        end
        chk("sched_halted", 32'(sched_halted), 32'(m_halted));
        tests++;
        assert (int'(dut.u_fifo.count) <= DEPTH) else begin
            failed++;
            $error("FAIL count_bound observed=%0d expected<=%0d", dut.u_fifo.count, DEPTH);
        end
        if (trk && debug_valid) begin
            chk("stream_pc", debug_pc, trk_pc);
            trk_pc += 32'd4;
            trk_n++;
        end
    endtask

    task automatic idle(input int n);
        bit a;
        set_l0(1'b0, mk(0, 0, 0, 0, 0));
        set_l1(1'b0, mk(0, 0, 0, 0, 0));
        repeat (n) cycle(a);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_l0(1'b0, mk(0, 0, 0, 0, 0));
        set_l1(1'b0, mk(0, 0, 0, 0, 0));
        repeat (2) @(posedge clock);
        #1;
        mq.delete();
        m_halt_taken = 1'b0;
        m_halted = 1'b0;
        chk("rst_valid", 32'(debug_valid), 0);
        chk("rst_halt", 32'(debug_halt), 0);
        chk("rst_regWen", 32'(debug_regWen), 0);
        chk("rst_pc", debug_pc, 0);
        chk("rst_regWaddr", 32'(debug_regWaddr), 0);
        chk("rst_regWdata", debug_regWdata, 0);
        chk("rst_sched_halted", 32'(sched_halted), 0);
        reset = 1'b0;
    endtask

    initial begin
        bit          acc;
        int          sent, cyc;
        logic [31:0] pc;

        do_reset();

        set_l0(1'b1, mk(32'h8000_0000, 1'b1, 5'd5, 32'h1234, 1'b0));
        cycle(acc);
        chk("single_pc", debug_pc, 32'h8000_0000);
        idle(1);
        chk("single_gone", 32'(debug_valid), 0);

        set_l0(1'b1, mk(32'h0000_0100, 1'b1, 5'd0, 32'hFFFF, 1'b0));
        cycle(acc);
        chk("x0_regWen", 32'(debug_regWen), 0);
        chk("x0_data", debug_regWdata, 32'hFFFF);
        idle(1);

        set_l1(1'b1, mk(32'h20, 1'b1, 5'd3, 32'h33, 1'b0));
        cycle(acc);
        chk("lane1_only_pc", debug_pc, 32'h20);
        set_l0(1'b1, mk(32'h24, 1'b1, 5'd4, 32'h44, 1'b0));
        set_l1(1'b1, mk(32'h28, 1'b1, 5'd6, 32'h66, 1'b0));
        cycle(acc);
        chk("pair_first_pc", debug_pc, 32'h24);
        idle(1);
        chk("pair_second_pc", debug_pc, 32'h28);
        idle(1);

        pc = 32'h0; sent = 0; cyc = 0;
        trk = 1'b1; trk_pc = 32'h0; trk_n = 0; saw_stall = 1'b0;
        set_l0(1'b1, mk(pc, 1'b1, 5'd1, pc, 1'b0));
        set_l1(1'b1, mk(pc + 4, 1'b1, 5'd2, pc + 4, 1'b0));
        while (sent < 100 && cyc < 400) begin
            if (!in_ready) saw_stall = 1'b1;
            cycle(acc);
            cyc++;
            if (acc) begin
                sent += 2;
                pc += 32'd8;
                set_l0(sent < 100, mk(pc, 1'b1, 5'd1, pc, 1'b0));
                set_l1(sent < 100, mk(pc + 4, 1'b1, 5'd2, pc + 4, 1'b0));
            end
        end
        chk("stream_sent", 32'(sent), 100);
        idle(6);
        trk = 1'b0;
        chk("stream_emitted", 32'(trk_n), 100);
        chk("stream_stall_seen", 32'(saw_stall), 1);

        acc = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (acc) begin
                set_l0(1'($urandom_range(0, 1)), mk($urandom, 1'($urandom), 5'($urandom), $urandom, 1'b0));
                set_l1(1'($urandom_range(0, 1)), mk($urandom, 1'($urandom), 5'($urandom), $urandom, 1'b0));
            end
            cycle(acc);
        end
        idle(6);

        for (int i = 0; i < 3; i++) begin
            set_l0(1'b1, mk(32'h200 + 32'(i * 8), 1'b1, 5'd7, 32'(i), 1'b0));
            set_l1(1'b1, mk(32'h204 + 32'(i * 8), 1'b1, 5'd8, 32'(i), 1'b0));
            cycle(acc);
        end
        chk("pre_reset_buffered", 32'(dut.u_fifo.count), 32'(mq.size()));
        do_reset();
        idle(2);
        set_l0(1'b1, mk(32'h40, 1'b1, 5'd9, 32'h99, 1'b0));
        cycle(acc);
        chk("post_reset_pc", debug_pc, 32'h40);
        chk("post_reset_sched", 32'(sched_halted), 0);
        idle(1);

        set_l0(1'b1, mk(32'h100, 1'b1, 5'd1, 32'h1, 1'b0));
        set_l1(1'b1, mk(32'h104, 1'b1, 5'd2, 32'h2, 1'b0));
        cycle(acc);
        set_l0(1'b1, mk(32'h108, 1'b1, 5'd3, 32'h3, 1'b0));
        set_l1(1'b1, mk(32'h10C, 1'b1, 5'd4, 32'h4, 1'b0));
        cycle(acc);
        set_l0(1'b1, mk(32'h10, 1'b1, 5'd5, 32'h5, 1'b1));
        set_l1(1'b1, mk(32'h14, 1'b1, 5'd6, 32'h6, 1'b0));
        cycle(acc);
        chk("halt_accepted", 32'(acc), 1);
        idle(2);
        chk("halt_pc", debug_pc, 32'h10);
        chk("halt_flag", 32'(debug_halt), 1);
        set_l0(1'b1, mk(32'h50, 1'b1, 5'd1, 32'h5, 1'b0));
        set_l1(1'b1, mk(32'h54, 1'b1, 5'd1, 32'h5, 1'b0));
        repeat (5) cycle(acc);
        chk("halt_sticky", 32'(sched_halted), 1);
        chk("halt_blocked", 32'(in_ready), 0);

        do_reset();
        set_l0(1'b1, mk(32'h30, 1'b0, 5'd0, 32'h0, 1'b1));
        cycle(acc);
        chk("bypass_halt", 32'(debug_halt), 1);
        chk("bypass_sched", 32'(sched_halted), 1);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
